// File: rtl/bus_pkg.sv
// Shared state type, master ids and default sizing for the serial system bus arbiter.
package bus_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SSEL    = 2'd1,
    BUSY    = 2'd2,
    RELEASE = 2'd3
  } state_t;

  localparam logic M1 = 1'b0;
  localparam logic M2 = 1'b1;

  localparam int unsigned SLAVE_LEN_DEF = 2;
  localparam int unsigned TIMEOUT_DEF   = 4096;
  localparam int unsigned TO_LEN_DEF    = 13;

  // On a tie the master that did not own the bus last time wins.
  function automatic logic rr_pick(input logic m1_req, input logic m2_req,
                                   input logic last_owner);
    if (m1_req && m2_req) begin
      return ~last_owner;
    end else if (m2_req) begin
      return M2;
    end
    return M1;
  endfunction

endpackage

// File: rtl/arb_rr_picker.sv
// Combinational two-master round-robin picker.
module arb_rr_picker
  import bus_pkg::*;
(
  input  logic m1_request,
  input  logic m2_request,
  input  logic last_owner,
  output logic valid,
  output logic winner
);

  always_comb begin
    valid  = m1_request | m2_request;
    winner = rr_pick(m1_request, m2_request, last_owner);
  end

endmodule

// File: rtl/bus_arbiter.sv
// Two-master bus arbiter: grant, serial slave-id capture, busy hold with timeout, one-cycle release.
module bus_arbiter
  import bus_pkg::*;
#(
  parameter int unsigned SLAVE_LEN = SLAVE_LEN_DEF,
  parameter int unsigned TIMEOUT   = TIMEOUT_DEF,
  parameter int unsigned TO_LEN    = TO_LEN_DEF
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      m1_request,
  input  logic                      m2_request,
  input  logic                      m1_slave_select,
  input  logic                      m2_slave_select,
  input  logic                      m1_trans_done,
  input  logic                      m2_trans_done,
  output logic                      m1_grant,
  output logic                      m2_grant,
  output logic                      arbitor_busy,
  output logic                      bus_busy,
  output logic                      master_sel,
  output logic [(2**SLAVE_LEN)-1:0] slave_en,
  output logic                      timeout_err
);

  localparam int unsigned NSLV = 2**SLAVE_LEN;
  localparam logic [SLAVE_LEN-1:0] BIT_LAST = SLAVE_LEN'(SLAVE_LEN - 1);
  localparam logic [TO_LEN-1:0]    TO_LAST  = TO_LEN'(TIMEOUT - 1);

  state_t               state_q, state_d;
  logic                 owner_q, owner_d;
  logic                 last_owner_q, last_owner_d;
  logic                 m1_grant_q, m1_grant_d;
  logic                 m2_grant_q, m2_grant_d;
  logic                 arb_busy_q, arb_busy_d;
  logic                 bus_busy_q, bus_busy_d;
  logic                 master_sel_q, master_sel_d;
  logic [NSLV-1:0]      slave_en_q, slave_en_d;
  logic                 timeout_err_q, timeout_err_d;
  logic [SLAVE_LEN-1:0] sr_q, sr_d;
  logic [SLAVE_LEN-1:0] bit_cnt_q, bit_cnt_d;
  logic [TO_LEN-1:0]    to_cnt_q, to_cnt_d;

  logic                 pick_valid;
  logic                 pick_winner;
  logic                 own_req;
  logic                 own_done;
  logic                 own_sel;
  logic [SLAVE_LEN:0]   sr_ext;
  logic [SLAVE_LEN-1:0] sr_shift;
  logic                 rel;

  arb_rr_picker u_picker (
    .m1_request (m1_request),
    .m2_request (m2_request),
    .last_owner (last_owner_q),
    .valid      (pick_valid),
    .winner     (pick_winner)
  );

  always_comb begin
    own_req  = (owner_q == M2) ? m2_request      : m1_request;
    own_done = (owner_q == M2) ? m2_trans_done   : m1_trans_done;
    own_sel  = (owner_q == M2) ? m2_slave_select : m1_slave_select;
    sr_ext   = {sr_q, own_sel};
    sr_shift = sr_ext[SLAVE_LEN-1:0];
  end

  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    last_owner_d  = last_owner_q;
    m1_grant_d    = m1_grant_q;
    m2_grant_d    = m2_grant_q;
    arb_busy_d    = arb_busy_q;
    bus_busy_d    = bus_busy_q;
    master_sel_d  = master_sel_q;
    slave_en_d    = slave_en_q;
    timeout_err_d = 1'b0;
    sr_d          = sr_q;
    bit_cnt_d     = bit_cnt_q;
    to_cnt_d      = to_cnt_q;
    rel           = 1'b0;

    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d      = SSEL;
          owner_d      = pick_winner;
          m1_grant_d   = (pick_winner == M1);
          m2_grant_d   = (pick_winner == M2);
          arb_busy_d   = 1'b1;
          master_sel_d = pick_winner;
          sr_d         = '0;
          bit_cnt_d    = '0;
          to_cnt_d     = '0;
        end
      end
      SSEL: begin
        if (!own_req) begin
          rel = 1'b1;
        end else begin
          sr_d = sr_shift;
          // The last serial bit feeds the slave decode directly, so enable is valid on BUSY entry.
          if (bit_cnt_q == BIT_LAST) begin
            state_d    = BUSY;
            bus_busy_d = 1'b1;
            slave_en_d = NSLV'(1) << sr_shift;
            to_cnt_d   = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + SLAVE_LEN'(1);
          end
        end
      end
      BUSY: begin
        // Withdrawal and trans_done take precedence over an expiring timeout.
        if (!own_req || own_done) begin
          rel = 1'b1;
        end else if (to_cnt_q == TO_LAST) begin
          rel           = 1'b1;
          timeout_err_d = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + TO_LEN'(1);
        end
      end
      RELEASE: begin
        state_d      = IDLE;
        arb_busy_d   = 1'b0;
        last_owner_d = owner_q;
        sr_d         = '0;
        bit_cnt_d    = '0;
        to_cnt_d     = '0;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (rel) begin
      state_d    = RELEASE;
      m1_grant_d = 1'b0;
      m2_grant_d = 1'b0;
      bus_busy_d = 1'b0;
      slave_en_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= IDLE;
      owner_q       <= M1;
      last_owner_q  <= M2;
      m1_grant_q    <= 1'b0;
      m2_grant_q    <= 1'b0;
      arb_busy_q    <= 1'b0;
      bus_busy_q    <= 1'b0;
      master_sel_q  <= 1'b0;
      slave_en_q    <= '0;
      timeout_err_q <= 1'b0;
      sr_q          <= '0;
      bit_cnt_q     <= '0;
      to_cnt_q      <= '0;
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      last_owner_q  <= last_owner_d;
      m1_grant_q    <= m1_grant_d;
      m2_grant_q    <= m2_grant_d;
      arb_busy_q    <= arb_busy_d;
      bus_busy_q    <= bus_busy_d;
      master_sel_q  <= master_sel_d;
      slave_en_q    <= slave_en_d;
      timeout_err_q <= timeout_err_d;
      sr_q          <= sr_d;
      bit_cnt_q     <= bit_cnt_d;
      to_cnt_q      <= to_cnt_d;
    end
  end

  always_comb begin
    m1_grant     = m1_grant_q;
    m2_grant     = m2_grant_q;
    arbitor_busy = arb_busy_q;
    bus_busy     = bus_busy_q;
    master_sel   = master_sel_q;
    slave_en     = slave_en_q;
    timeout_err  = timeout_err_q;
  end

endmodule
